// File: rtl/dac_seq_pkg.sv
// ============================================================================
// dac_seq_pkg
// Shared definitions for the DAC ramp sequencer.
//   - state_t       : sequencer state (IDLE / RAMP)
//   - OP_*          : command opcodes carried in cmd_word[23:22]
//   - *_MSB/*_LSB   : bit positions of the command word fields
//   - cmd_t         : decoded command (interval/step already forced non-zero)
//   - decode_cmd()  : splits a raw 24-bit command word into a cmd_t
// ============================================================================
package dac_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    localparam logic [1:0] OP_SET   = 2'd0;
    localparam logic [1:0] OP_RAMP  = 2'd1;
    localparam logic [1:0] OP_ABORT = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    // Command word layout
    localparam int CMD_W    = 24;
    localparam int OP_MSB   = 23;
    localparam int OP_LSB   = 22;
    localparam int INT_MSB  = 21;
    localparam int INT_LSB  = 12;
    localparam int STEP_MSB = 11;
    localparam int STEP_LSB = 8;
    localparam int TGT_MSB  = 7;
    localparam int TGT_LSB  = 0;

    localparam int CMD_IW = INT_MSB - INT_LSB + 1;
    localparam int CMD_SW = STEP_MSB - STEP_LSB + 1;
    localparam int CMD_TW = TGT_MSB - TGT_LSB + 1;

    typedef struct packed {
        logic [1:0]        op;
        logic [CMD_IW-1:0] interval;
        logic [CMD_SW-1:0] step;
        logic [CMD_TW-1:0] target;
    } cmd_t;

    // Zero interval and zero step are promoted to 1 here so the datapath
    // never has to special-case them. Target clamping depends on the DAC
    // size and is done by the consumer.
    function automatic cmd_t decode_cmd(input logic [CMD_W-1:0] word);
        cmd_t c;
        c.op       = word[OP_MSB:OP_LSB];
        c.interval = word[INT_MSB:INT_LSB];
        c.step     = word[STEP_MSB:STEP_LSB];
        c.target   = word[TGT_MSB:TGT_LSB];
        if (c.interval == '0) c.interval = CMD_IW'(1);
        if (c.step == '0)     c.step     = CMD_SW'(1);
        return c;
    endfunction

endpackage

// File: rtl/ramp_step.sv
// ============================================================================
// ramp_step
// Combinational next-code calculator for one ramp step.
// Ports:
//   code      in  NB  current DAC code
//   target    in  NB  ramp end point (already clamped to the DAC range)
//   step      in  SW  step size (non-zero)
//   dir_up    in  1   1 = ramp upward, 0 = downward
//   next_code out NB  code after one step, saturated at target
//   reached   out 1   next_code equals target
// Arithmetic is carried at NB+SW+1 bits so code+step can never wrap and
// the down-direction comparison never goes negative.
// ============================================================================
module ramp_step #(
    parameter int NB = 8,
    parameter int SW = 4
) (
    input  logic [NB-1:0] code,
    input  logic [NB-1:0] target,
    input  logic [SW-1:0] step,
    input  logic          dir_up,
    output logic [NB-1:0] next_code,
    output logic          reached
);

    localparam int W = NB + SW + 1;

    logic [W-1:0] code_w;
    logic [W-1:0] target_w;
    logic [W-1:0] step_w;
    logic [W-1:0] next_w;

    always_comb begin
        code_w   = W'(code);
        target_w = W'(target);
        step_w   = W'(step);
        next_w   = target_w;
        if (dir_up) begin
            // min(code + step, target)
            if (code_w + step_w < target_w) next_w = code_w + step_w;
        end else begin
            // max(code - step, target), written without a subtraction that
            // could underflow
            if (code_w > target_w + step_w) next_w = code_w - step_w;
        end
        next_code = NB'(next_w);
        reached   = (next_w == target_w);
    end

endmodule

// File: rtl/dac_ramp_ctrl.sv
// ============================================================================
// dac_ramp_ctrl
// Command sequencer for the current-steering DAC. Decodes 24-bit command
// words (SET / RAMP / ABORT / CLEAR) and drives a registered DAC code,
// either immediately or as a slew-limited ramp (fixed step every
// `interval` clocks until the target is reached).
// Ports:
//   r_Clk     in   1   system clock, rising edge
//   r_Rst     in   1   synchronous active-high reset
//   cmd_valid in   1   command word present this cycle
//   cmd_ready out  1   command accepted this cycle (low only in reset)
//   cmd_word  in   24  [23:22] op, [21:12] interval, [11:8] step, [7:0] target
//   dac_code  out  NB  registered DAC code
//   busy      out  1   high while ramping
//   done      out  1   one-cycle pulse when dac_code reaches the commanded value
// ============================================================================
module dac_ramp_ctrl
    import dac_seq_pkg::*;
#(
    parameter int N  = 256,
    parameter int NB = $clog2(N),
    parameter int IW = CMD_IW,
    parameter int SW = CMD_SW
) (
    input  logic          r_Clk,
    input  logic          r_Rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [23:0]   cmd_word,
    output logic [NB-1:0] dac_code,
    output logic          busy,
    output logic          done
);

    state_t        state_reg;
    logic [NB-1:0] code_reg;
    logic [NB-1:0] target_reg;
    logic [SW-1:0] step_reg;
    logic [IW-1:0] interval_reg;
    logic [IW-1:0] cnt_reg;
    logic          dir_up_reg;
    logic          busy_reg;
    logic          done_reg;

    cmd_t          cmd;
    logic [NB-1:0] cmd_target;
    logic          cmd_accept;
    logic [NB-1:0] step_code;
    logic          step_reached;

    assign cmd_ready  = ~r_Rst;
    assign cmd_accept = cmd_valid & cmd_ready;

    // Decode and clamp the incoming command.
    always_comb begin
        cmd        = decode_cmd(cmd_word);
        cmd_target = NB'(cmd.target);
        if (int'(cmd.target) > N - 1) cmd_target = NB'(N - 1);
    end

    ramp_step #(
        .NB (NB),
        .SW (SW)
    ) u_ramp_step (
        .code      (code_reg),
        .target    (target_reg),
        .step      (step_reg),
        .dir_up    (dir_up_reg),
        .next_code (step_code),
        .reached   (step_reached)
    );

    // An accepted command always has priority over a pending ramp step, so
    // preemption simply means the RAMP branch below is not taken that cycle.
    always_ff @(posedge r_Clk) begin
        if (r_Rst) begin
            state_reg    <= IDLE;
            code_reg     <= '0;
            target_reg   <= '0;
            step_reg     <= '0;
            interval_reg <= '0;
            cnt_reg      <= '0;
            dir_up_reg   <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (cmd_accept) begin
                case (cmd.op)
                    OP_SET: begin
                        code_reg  <= cmd_target;
                        done_reg  <= 1'b1;
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                    OP_RAMP: begin
                        if (cmd_target == code_reg) begin
                            // Already there: complete without ramping.
                            done_reg  <= 1'b1;
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end else begin
                            target_reg   <= cmd_target;
                            step_reg     <= SW'(cmd.step);
                            interval_reg <= IW'(cmd.interval);
                            cnt_reg      <= IW'(cmd.interval);
                            dir_up_reg   <= (cmd_target > code_reg);
                            state_reg    <= RAMP;
                            busy_reg     <= 1'b1;
                        end
                    end
                    OP_ABORT: begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                    default: begin // OP_CLEAR
                        code_reg  <= '0;
                        done_reg  <= 1'b1;
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end else if (state_reg == RAMP) begin
                // The step lands on the edge where the counter reads 1, which
                // puts the first update exactly `interval` edges after accept.
                if (cnt_reg == IW'(1)) begin
                    code_reg <= step_code;
                    cnt_reg  <= interval_reg;
                    if (step_reached) begin
                        done_reg  <= 1'b1;
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end else begin
                    cnt_reg <= cnt_reg - IW'(1);
                end
            end
        end
    end

    assign dac_code = code_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_dac_ramp_ctrl.sv
// ============================================================================
// tb_dac_ramp_ctrl
// Directed bench for dac_ramp_ctrl. Two instances share clock and reset:
// dut_a uses the default N=256, dut_b uses N=200 to exercise target clamping.
// Outputs are sampled 1 time unit after the rising edge; commands are driven
// on the falling edge and accepted on the following rising edge.
// ============================================================================
module tb_dac_ramp_ctrl;

    logic        r_Clk = 1'b0;
    logic        r_Rst = 1'b1;
    logic        cmd_valid_a = 1'b0;
    logic        cmd_valid_b = 1'b0;
    logic [23:0] cmd_word_a = '0;
    logic [23:0] cmd_word_b = '0;
    logic        cmd_ready_a, cmd_ready_b;
    logic [7:0]  dac_code_a, dac_code_b;
    logic        busy_a, busy_b, done_a, done_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 r_Clk = ~r_Clk;

    dac_ramp_ctrl #(.N(256)) dut_a (
        .r_Clk     (r_Clk),
        .r_Rst     (r_Rst),
        .cmd_valid (cmd_valid_a),
        .cmd_ready (cmd_ready_a),
        .cmd_word  (cmd_word_a),
        .dac_code  (dac_code_a),
        .busy      (busy_a),
        .done      (done_a)
    );

    dac_ramp_ctrl #(.N(200)) dut_b (
        .r_Clk     (r_Clk),
        .r_Rst     (r_Rst),
        .cmd_valid (cmd_valid_b),
        .cmd_ready (cmd_ready_b),
        .cmd_word  (cmd_word_b),
        .dac_code  (dac_code_b),
        .busy      (busy_b),
        .done      (done_b)
    );

    function automatic logic [23:0] mk(input logic [1:0] op, input logic [9:0] iv,
                                       input logic [3:0] st, input logic [7:0] tg);
        return {op, iv, st, tg};
    endfunction

    task automatic tick;
        @(posedge r_Clk);
        #1;
    endtask

    // Returns 1 time unit after the accept edge.
    task automatic issue(input bit to_b, input logic [23:0] w);
        @(negedge r_Clk);
        if (to_b) begin
            cmd_valid_b = 1'b1;
            cmd_word_b  = w;
        end else begin
            cmd_valid_a = 1'b1;
            cmd_word_a  = w;
        end
        @(posedge r_Clk);
        #1;
        cmd_valid_a = 1'b0;
        cmd_valid_b = 1'b0;
        $display("cmd %s word=%06h -> code=%0d busy=%0b done=%0b", to_b ? "B" : "A", w,
                 to_b ? dac_code_b : dac_code_a, to_b ? busy_b : busy_a, to_b ? done_b : done_a);
    endtask

    task automatic test_reset;
        tick;
        n_cmp++;
        if (cmd_ready_a !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %0b want 0", cmd_ready_a); end
        tick;
        n_cmp++;
        if (dac_code_a !== 8'd0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
            n_bad++; $display("FAIL reset_state got code=%0d busy=%0b done=%0b want 0/0/0", dac_code_a, busy_a, done_a);
        end
        @(negedge r_Clk);
        r_Rst = 1'b0;
        #1;
        n_cmp++;
        if (cmd_ready_a !== 1'b1) begin n_bad++; $display("FAIL ready_after_reset got %0b want 1", cmd_ready_a); end
        $display("reset released code=%0d", dac_code_a);
    endtask

    task automatic test_set;
        issue(0, mk(2'd0, 10'd0, 4'd0, 8'h40));
        n_cmp++;
        if (dac_code_a !== 8'h40 || done_a !== 1'b1 || busy_a !== 1'b0) begin
            n_bad++; $display("FAIL set_apply got code=%0d done=%0b busy=%0b want 64/1/0", dac_code_a, done_a, busy_a);
        end
        tick;
        n_cmp++;
        if (dac_code_a !== 8'h40 || done_a !== 1'b0 || busy_a !== 1'b0) begin
            n_bad++; $display("FAIL set_after got code=%0d done=%0b busy=%0b want 64/0/0", dac_code_a, done_a, busy_a);
        end
    endtask

    task automatic test_clear;
        issue(0, mk(2'd3, 10'd0, 4'd0, 8'd0));
        n_cmp++;
        if (dac_code_a !== 8'd0 || done_a !== 1'b1) begin
            n_bad++; $display("FAIL clear got code=%0d done=%0b want 0/1", dac_code_a, done_a);
        end
        tick;
        n_cmp++;
        if (done_a !== 1'b0) begin n_bad++; $display("FAIL clear_done_pulse got %0b want 0", done_a); end
    endtask

    task automatic test_ramp_up;
        int exp_code;
        int busy_cycles;
        issue(0, mk(2'd1, 10'd4, 4'd3, 8'd10));
        busy_cycles = 0;
        n_cmp++;
        if (dac_code_a !== 8'd0 || busy_a !== 1'b1 || done_a !== 1'b0) begin
            n_bad++; $display("FAIL up_accept got code=%0d busy=%0b done=%0b want 0/1/0", dac_code_a, busy_a, done_a);
        end
        if (busy_a === 1'b1) busy_cycles++;
        for (int k = 1; k <= 17; k++) begin
            tick;
            exp_code = (k / 4) * 3;
            if (exp_code > 10) exp_code = 10;
            n_cmp++;
            if (dac_code_a !== 8'(exp_code) || done_a !== (k == 16) || busy_a !== (k < 16)) begin
                n_bad++;
                $display("FAIL up_k%0d got code=%0d done=%0b busy=%0b want %0d/%0b/%0b",
                         k, dac_code_a, done_a, busy_a, exp_code, k == 16, k < 16);
            end
            if (busy_a === 1'b1) busy_cycles++;
        end
        n_cmp++;
        if (busy_cycles != 16) begin n_bad++; $display("FAIL up_busy_len got %0d want 16", busy_cycles); end
    endtask

    task automatic test_ramp_down;
        int exp_code;
        int n_done;
        issue(0, mk(2'd0, 10'd0, 4'd0, 8'd200));
        issue(0, mk(2'd1, 10'd1, 4'd15, 8'd5));
        n_done = 0;
        n_cmp++;
        if (dac_code_a !== 8'd200 || busy_a !== 1'b1 || done_a !== 1'b0) begin
            n_bad++; $display("FAIL down_accept got code=%0d busy=%0b done=%0b want 200/1/0", dac_code_a, busy_a, done_a);
        end
        for (int k = 1; k <= 15; k++) begin
            tick;
            exp_code = 200 - 15 * k;
            if (exp_code < 5) exp_code = 5;
            if (done_a === 1'b1) n_done++;
            n_cmp++;
            if (dac_code_a !== 8'(exp_code) || done_a !== (k == 13) || busy_a !== (k < 13)) begin
                n_bad++;
                $display("FAIL down_k%0d got code=%0d done=%0b busy=%0b want %0d/%0b/%0b",
                         k, dac_code_a, done_a, busy_a, exp_code, k == 13, k < 13);
            end
        end
        n_cmp++;
        if (n_done != 1) begin n_bad++; $display("FAIL down_done_count got %0d want 1", n_done); end
    endtask

    // Starts from code 5. Steps are due at accept+3 and accept+6; ABORT
    // is accepted on the accept+6 edge, so the second step must be lost.
    task automatic test_abort;
        issue(0, mk(2'd1, 10'd3, 4'd10, 8'd100));
        tick; tick; tick;
        n_cmp++;
        if (dac_code_a !== 8'd15) begin n_bad++; $display("FAIL abort_first_step got %0d want 15", dac_code_a); end
        tick; tick;
        issue(0, mk(2'd2, 10'd0, 4'd0, 8'd0));
        n_cmp++;
        if (dac_code_a !== 8'd15 || busy_a !== 1'b0 || done_a !== 1'b0) begin
            n_bad++; $display("FAIL abort_apply got code=%0d busy=%0b done=%0b want 15/0/0", dac_code_a, busy_a, done_a);
        end
        for (int k = 0; k < 4; k++) begin
            tick;
            n_cmp++;
            if (dac_code_a !== 8'd15 || busy_a !== 1'b0 || done_a !== 1'b0) begin
                n_bad++; $display("FAIL abort_hold%0d got code=%0d busy=%0b done=%0b want 15/0/0", k, dac_code_a, busy_a, done_a);
            end
        end
        issue(0, mk(2'd3, 10'd0, 4'd0, 8'd0));
        n_cmp++;
        if (dac_code_a !== 8'd0 || done_a !== 1'b1) begin
            n_bad++; $display("FAIL abort_clear got code=%0d done=%0b want 0/1", dac_code_a, done_a);
        end
    endtask

    task automatic test_clamp;
        int exp_code;
        issue(1, mk(2'd1, 10'd1, 4'd15, 8'hFF));
        for (int k = 1; k <= 15; k++) begin
            tick;
            exp_code = 15 * k;
            if (exp_code > 199) exp_code = 199;
            n_cmp++;
            if (dac_code_b !== 8'(exp_code) || done_b !== (k == 14) || busy_b !== (k < 14)) begin
                n_bad++;
                $display("FAIL clamp_k%0d got code=%0d done=%0b busy=%0b want %0d/%0b/%0b",
                         k, dac_code_b, done_b, busy_b, exp_code, k == 14, k < 14);
            end
        end
    endtask

    // Code is 0 here; zero step and zero interval behave as 1.
    task automatic test_step_zero;
        int exp_code;
        issue(0, mk(2'd1, 10'd0, 4'd0, 8'd3));
        for (int k = 1; k <= 4; k++) begin
            tick;
            exp_code = (k > 3) ? 3 : k;
            n_cmp++;
            if (dac_code_a !== 8'(exp_code) || done_a !== (k == 3) || busy_a !== (k < 3)) begin
                n_bad++;
                $display("FAIL zero_k%0d got code=%0d done=%0b busy=%0b want %0d/%0b/%0b",
                         k, dac_code_a, done_a, busy_a, exp_code, k == 3, k < 3);
            end
        end
    endtask

    task automatic test_ramp_same;
        issue(0, mk(2'd1, 10'd7, 4'd5, 8'd3));
        n_cmp++;
        if (dac_code_a !== 8'd3 || done_a !== 1'b1 || busy_a !== 1'b0) begin
            n_bad++; $display("FAIL same_accept got code=%0d done=%0b busy=%0b want 3/1/0", dac_code_a, done_a, busy_a);
        end
        tick;
        n_cmp++;
        if (done_a !== 1'b0 || busy_a !== 1'b0) begin
            n_bad++; $display("FAIL same_after got done=%0b busy=%0b want 0/0", done_a, busy_a);
        end
    endtask

    // A second RAMP mid-ramp restarts the interval from its own accept edge.
    task automatic test_back_to_back;
        issue(0, mk(2'd1, 10'd5, 4'd1, 8'd50));
        tick; tick;
        issue(0, mk(2'd1, 10'd2, 4'd4, 8'd50));
        n_cmp++;
        if (dac_code_a !== 8'd3 || busy_a !== 1'b1) begin
            n_bad++; $display("FAIL b2b_accept got code=%0d busy=%0b want 3/1", dac_code_a, busy_a);
        end
        tick;
        n_cmp++;
        if (dac_code_a !== 8'd3) begin n_bad++; $display("FAIL b2b_k1 got %0d want 3", dac_code_a); end
        tick;
        n_cmp++;
        if (dac_code_a !== 8'd7) begin n_bad++; $display("FAIL b2b_k2 got %0d want 7", dac_code_a); end
        tick; tick;
        n_cmp++;
        if (dac_code_a !== 8'd11) begin n_bad++; $display("FAIL b2b_k4 got %0d want 11", dac_code_a); end
    endtask

    task automatic test_reset_mid;
        int exp_code;
        issue(0, mk(2'd0, 10'd0, 4'd0, 8'h30));
        issue(0, mk(2'd1, 10'd1, 4'd3, 8'h40));
        tick;
        n_cmp++;
        if (dac_code_a !== 8'h33) begin n_bad++; $display("FAIL rst_pre got %0d want 51", dac_code_a); end
        @(negedge r_Clk);
        r_Rst = 1'b1;
        #1;
        n_cmp++;
        if (cmd_ready_a !== 1'b0) begin n_bad++; $display("FAIL rst_ready got %0b want 0", cmd_ready_a); end
        @(posedge r_Clk);
        #1;
        r_Rst = 1'b0;
        n_cmp++;
        if (dac_code_a !== 8'd0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid got code=%0d busy=%0b done=%0b want 0/0/0", dac_code_a, busy_a, done_a);
        end
        tick;
        n_cmp++;
        if (dac_code_a !== 8'd0 || done_a !== 1'b0 || cmd_ready_a !== 1'b1) begin
            n_bad++; $display("FAIL rst_post got code=%0d done=%0b ready=%0b want 0/0/1", dac_code_a, done_a, cmd_ready_a);
        end
        issue(0, mk(2'd1, 10'd2, 4'd1, 8'd2));
        for (int k = 1; k <= 5; k++) begin
            tick;
            exp_code = k / 2;
            if (exp_code > 2) exp_code = 2;
            n_cmp++;
            if (dac_code_a !== 8'(exp_code) || done_a !== (k == 4) || busy_a !== (k < 4)) begin
                n_bad++;
                $display("FAIL rst_ramp_k%0d got code=%0d done=%0b busy=%0b want %0d/%0b/%0b",
                         k, dac_code_a, done_a, busy_a, exp_code, k == 4, k < 4);
            end
        end
    endtask

    initial begin
        test_reset;
        test_set;
        test_clear;
        test_ramp_up;
        test_ramp_down;
        test_abort;
        test_clamp;
        test_step_zero;
        test_ramp_same;
        test_back_to_back;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
